// File: rtl/cab_panel_pkg.sv
// Shared types and constants for the cabinet-side MVS panel receiver.
// Holds the EL FSM state enum, 7-segment lookup constants and parameter defaults.
package cab_panel_pkg;

  localparam int EL_BEATS_DEF    = 8;
  localparam int EL_TIMEOUT_DEF  = 1024;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    EL_IDLE = 1'b0,
    EL_RECV = 1'b1
  } el_state_t;

  // Segment patterns, bit order gfedcba, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic bcd_bad(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  function automatic logic [6:0] bcd_val(input logic [7:0] b);
    logic [6:0] hi;
    logic [6:0] lo;
    hi = {3'b000, b[7:4]};
    lo = {3'b000, b[3:0]};
    return (hi << 3) + (hi << 1) + lo;
  endfunction

endpackage

// File: rtl/cab_panel_rx_strobe_sync.sv
// Multi-flop synchroniser for a strobe plus data bus, with strobe rising-edge detect.
module strobe_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic [WIDTH-1:0] data,
  output logic             rise,
  output logic [WIDTH-1:0] data_sync
);

  logic [SYNC_STAGES-1:0][WIDTH:0] chain;
  logic                            strobe_d;

  // Strobe travels in the top bit so it sees exactly the same delay as its data.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain    <= '0;
      strobe_d <= 1'b0;
    end else begin
      chain[0] <= {strobe, data};
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      strobe_d <= chain[SYNC_STAGES-1][WIDTH];
    end
  end

  assign rise      = chain[SYNC_STAGES-1][WIDTH] & ~strobe_d;
  assign data_sync = chain[SYNC_STAGES-1][WIDTH-1:0];

endmodule

// File: rtl/cab_panel_rx.sv
// Cabinet-side receiver for MVS panel LED and EL traffic.
// Optional 7-segment decode is built when CAB_PANEL_SEG_DECODE_EN is defined.
module cab_panel_rx
  import cab_panel_pkg::*;
#(
  parameter int EL_BEATS    = EL_BEATS_DEF,
  parameter int EL_TIMEOUT  = EL_TIMEOUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  MCLK,
  input  logic                  RESET,
  input  logic [8:0]            LED_OUT1,
  input  logic [8:0]            LED_OUT2,
  input  logic [3:0]            EL_OUT,
  output logic [7:0]            LED1_DATA,
  output logic [7:0]            LED2_DATA,
  output logic [6:0]            LED1_VAL,
  output logic [6:0]            LED2_VAL,
  output logic [1:0]            LED_BCD_ERR,
  output logic [1:0]            LED_UPD,
  output logic [3*EL_BEATS-1:0] EL_FRAME,
  output logic                  EL_VALID,
  output logic                  EL_ERR,
  output logic [13:0]           SEG1,
  output logic [13:0]           SEG2
);

  localparam int FW    = 3 * EL_BEATS;
  localparam int CNT_W = $clog2(EL_BEATS + 1);
  localparam int TO_W  = $clog2(EL_TIMEOUT);

  logic [1:0]      led_rise;
  logic [1:0][7:0] led_sync;
  logic [1:0][7:0] led_data;
  logic [1:0][6:0] led_val;
  logic [1:0]      bcd_err;
  logic [1:0]      led_upd;
  logic            el_rise;
  logic [2:0]      el_sync;

  strobe_sync #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES)) u_sync_led1 (
    .clk(MCLK), .reset(RESET), .strobe(LED_OUT1[8]), .data(LED_OUT1[7:0]),
    .rise(led_rise[0]), .data_sync(led_sync[0])
  );

  strobe_sync #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES)) u_sync_led2 (
    .clk(MCLK), .reset(RESET), .strobe(LED_OUT2[8]), .data(LED_OUT2[7:0]),
    .rise(led_rise[1]), .data_sync(led_sync[1])
  );

  strobe_sync #(.WIDTH(3), .SYNC_STAGES(SYNC_STAGES)) u_sync_el (
    .clk(MCLK), .reset(RESET), .strobe(EL_OUT[3]), .data(EL_OUT[2:0]),
    .rise(el_rise), .data_sync(el_sync)
  );

  // BCD error flags are sticky until reset; a bad byte reports value 0.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      led_data <= '0;
      led_val  <= '0;
      bcd_err  <= '0;
      led_upd  <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        led_upd[n] <= led_rise[n];
        if (led_rise[n]) begin
          led_data[n] <= led_sync[n];
          if (bcd_bad(led_sync[n])) begin
            led_val[n] <= '0;
            bcd_err[n] <= 1'b1;
          end else begin
            led_val[n] <= bcd_val(led_sync[n]);
          end
        end
      end
    end
  end

  assign LED1_DATA   = led_data[0];
  assign LED2_DATA   = led_data[1];
  assign LED1_VAL    = led_val[0];
  assign LED2_VAL    = led_val[1];
  assign LED_BCD_ERR = bcd_err;
  assign LED_UPD     = led_upd;

`ifdef CAB_PANEL_SEG_DECODE_EN
  logic [1:0][13:0] seg;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      seg <= '0;
    end else begin
      for (int n = 0; n < 2; n++)
        if (led_rise[n]) seg[n] <= {seg7(led_sync[n][7:4]), seg7(led_sync[n][3:0])};
    end
  end

  assign SEG1 = seg[0];
  assign SEG2 = seg[1];
`else
  assign SEG1 = '0;
  assign SEG2 = '0;
`endif

  el_state_t        state, state_n;
  logic [CNT_W-1:0] beat_cnt, cnt_n;
  logic [TO_W-1:0]  to_cnt, to_n;
  logic [FW-1:0]    shift, shift_n;
  logic [FW-1:0]    el_frame, frame_n;
  logic             el_valid, valid_n;
  logic             el_err, err_n;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state    <= EL_IDLE;
      beat_cnt <= '0;
      to_cnt   <= '0;
      shift    <= '0;
      el_frame <= '0;
      el_valid <= 1'b0;
      el_err   <= 1'b0;
    end else begin
      state    <= state_n;
      beat_cnt <= cnt_n;
      to_cnt   <= to_n;
      shift    <= shift_n;
      el_frame <= frame_n;
      el_valid <= valid_n;
      el_err   <= err_n;
    end
  end

  // An edge always beats a coincident timeout; the frame output only moves on completion.
  always_comb begin
    state_n = state;
    cnt_n   = beat_cnt;
    to_n    = to_cnt;
    shift_n = shift;
    frame_n = el_frame;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      EL_IDLE: begin
        to_n = '0;
        if (el_rise) begin
          shift_n      = '0;
          shift_n[2:0] = el_sync;
          if (EL_BEATS == 1) begin
            frame_n = shift_n;
            valid_n = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n   = CNT_W'(1);
            state_n = EL_RECV;
          end
        end
      end
      EL_RECV: begin
        if (el_rise) begin
          to_n = '0;
          for (int i = 0; i < EL_BEATS; i++)
            if (beat_cnt == CNT_W'(i)) shift_n[3*i +: 3] = el_sync;
          if (beat_cnt == CNT_W'(EL_BEATS - 1)) begin
            frame_n = shift_n;
            valid_n = 1'b1;
            cnt_n   = '0;
            state_n = EL_IDLE;
          end else begin
            cnt_n = beat_cnt + 1'b1;
          end
        end else if (to_cnt == TO_W'(EL_TIMEOUT - 1)) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          to_n    = '0;
          shift_n = '0;
          state_n = EL_IDLE;
        end else begin
          to_n = to_cnt + 1'b1;
        end
      end
      default: state_n = EL_IDLE;
    endcase
  end

  assign EL_FRAME = el_frame;
  assign EL_VALID = el_valid;
  assign EL_ERR   = el_err;

endmodule

// File: tb/tb_cab_panel_rx.sv
// Directed bench for cab_panel_rx: LED vector table plus hand-written EL frame sequences.
module tb_cab_panel_rx;

  logic        MCLK;
  logic        RESET;
  logic [8:0]  LED_OUT1;
  logic [8:0]  LED_OUT2;
  logic [3:0]  EL_OUT;
  logic [7:0]  LED1_DATA;
  logic [7:0]  LED2_DATA;
  logic [6:0]  LED1_VAL;
  logic [6:0]  LED2_VAL;
  logic [1:0]  LED_BCD_ERR;
  logic [1:0]  LED_UPD;
  logic [23:0] EL_FRAME;
  logic        EL_VALID;
  logic        EL_ERR;
  logic [13:0] SEG1;
  logic [13:0] SEG2;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;

  cab_panel_rx dut (
    .MCLK(MCLK), .RESET(RESET), .LED_OUT1(LED_OUT1), .LED_OUT2(LED_OUT2),
    .EL_OUT(EL_OUT), .LED1_DATA(LED1_DATA), .LED2_DATA(LED2_DATA),
    .LED1_VAL(LED1_VAL), .LED2_VAL(LED2_VAL), .LED_BCD_ERR(LED_BCD_ERR),
    .LED_UPD(LED_UPD), .EL_FRAME(EL_FRAME), .EL_VALID(EL_VALID), .EL_ERR(EL_ERR),
    .SEG1(SEG1), .SEG2(SEG2)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  always @(posedge MCLK) begin
    #1;
    if (EL_VALID) valid_cnt++;
    if (EL_ERR) err_cnt++;
  end

  typedef struct {
    logic       ch;
    logic [7:0] data;
    logic [6:0] val;
    logic [1:0] err;
    logic [6:0] seg_hi;
    logic [6:0] seg_lo;
  } led_vec_t;

  led_vec_t vecs [8];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Raise one LED strobe, watch 12 cycles for the update pulse and its latency.
  task automatic apply_stimulus(input logic ch, input logic [7:0] data,
                                output int upd_n, output int first);
    upd_n = 0;
    first = -1;
    @(negedge MCLK);
    if (ch) LED_OUT2 = {1'b1, data}; else LED_OUT1 = {1'b1, data};
    for (int i = 1; i <= 12; i++) begin
      @(negedge MCLK);
      if (LED_UPD[ch]) begin
        upd_n++;
        if (first < 0) first = i;
      end
      if (i == 8) begin
        if (ch) LED_OUT2 = {1'b0, data}; else LED_OUT1 = {1'b0, data};
      end
    end
  endtask

  task automatic el_beat(input logic [2:0] d);
    @(negedge MCLK);
    EL_OUT = {1'b1, d};
    repeat (4) @(negedge MCLK);
    EL_OUT = {1'b0, d};
    repeat (4) @(negedge MCLK);
  endtask

  initial begin
    int upd_n;
    int first;
    int vbase;
    int ebase;
    logic [13:0] exp_seg;

    vecs[0] = '{1'b0, 8'h42, 7'd42, 2'b00, 7'h66, 7'h5B};
    vecs[1] = '{1'b1, 8'h3A, 7'd0,  2'b10, 7'h4F, 7'h00};
    vecs[2] = '{1'b1, 8'h07, 7'd7,  2'b10, 7'h3F, 7'h07};
    vecs[3] = '{1'b0, 8'h99, 7'd99, 2'b10, 7'h6F, 7'h6F};
    vecs[4] = '{1'b0, 8'h00, 7'd0,  2'b10, 7'h3F, 7'h3F};
    vecs[5] = '{1'b0, 8'h18, 7'd18, 2'b10, 7'h06, 7'h7F};
    vecs[6] = '{1'b0, 8'hF5, 7'd0,  2'b11, 7'h00, 7'h6D};
    vecs[7] = '{1'b1, 8'h90, 7'd90, 2'b11, 7'h6F, 7'h3F};

    RESET = 1'b1;
    LED_OUT1 = '0;
    LED_OUT2 = '0;
    EL_OUT = '0;
    repeat (5) @(negedge MCLK);
    RESET = 1'b0;
    @(negedge MCLK);

    check_output("reset_led1_data", {24'd0, LED1_DATA}, 32'd0);
    check_output("reset_led2_val", {25'd0, LED2_VAL}, 32'd0);
    check_output("reset_bcd_err", {30'd0, LED_BCD_ERR}, 32'd0);
    check_output("reset_upd", {30'd0, LED_UPD}, 32'd0);
    check_output("reset_el_frame", {8'd0, EL_FRAME}, 32'd0);
    check_output("reset_el_pulses", {30'd0, EL_VALID, EL_ERR}, 32'd0);
    check_output("reset_seg", {4'd0, SEG1, SEG2}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      apply_stimulus(vecs[v].ch, vecs[v].data, upd_n, first);
`ifdef CAB_PANEL_SEG_DECODE_EN
      exp_seg = {vecs[v].seg_hi, vecs[v].seg_lo};
`else
      exp_seg = 14'd0;
`endif
      check_output($sformatf("led_upd_count[%0d]", v), upd_n, 1);
      check_output($sformatf("led_upd_latency[%0d]", v), first, 3);
      check_output($sformatf("led_data[%0d]", v),
                   {24'd0, vecs[v].ch ? LED2_DATA : LED1_DATA}, {24'd0, vecs[v].data});
      check_output($sformatf("led_val[%0d]", v),
                   {25'd0, vecs[v].ch ? LED2_VAL : LED1_VAL}, {25'd0, vecs[v].val});
      check_output($sformatf("led_bcd_err[%0d]", v), {30'd0, LED_BCD_ERR}, {30'd0, vecs[v].err});
      check_output($sformatf("led_seg[%0d]", v),
                   {18'd0, vecs[v].ch ? SEG2 : SEG1}, {18'd0, exp_seg});
    end

    // Both LED channels strobed in the same cycle.
    upd_n = 0;
    @(negedge MCLK);
    LED_OUT1 = {1'b1, 8'h55};
    LED_OUT2 = {1'b1, 8'h66};
    for (int i = 1; i <= 12; i++) begin
      @(negedge MCLK);
      if (LED_UPD == 2'b11) upd_n++;
      if (i == 8) begin
        LED_OUT1 = {1'b0, 8'h55};
        LED_OUT2 = {1'b0, 8'h66};
      end
    end
    check_output("dual_upd", upd_n, 1);
    check_output("dual_val1", {25'd0, LED1_VAL}, 32'd55);
    check_output("dual_val2", {25'd0, LED2_VAL}, 32'd66);
    check_output("dual_err_sticky", {30'd0, LED_BCD_ERR}, 32'd3);

    // Clean 8-beat frame carrying 0..7.
    vbase = valid_cnt;
    ebase = err_cnt;
    for (int b = 0; b < 7; b++) el_beat(3'(b));
    check_output("el_no_early_valid", valid_cnt - vbase, 0);
    el_beat(3'd7);
    repeat (4) @(negedge MCLK);
    check_output("el_frame1_valid", valid_cnt - vbase, 1);
    check_output("el_frame1", {8'd0, EL_FRAME}, 32'h00FAC688);
    check_output("el_frame1_err", err_cnt - ebase, 0);

    // Partial frame abandoned by timeout, then a clean frame.
    vbase = valid_cnt;
    ebase = err_cnt;
    el_beat(3'd1);
    el_beat(3'd2);
    el_beat(3'd3);
    repeat (1100) @(negedge MCLK);
    check_output("el_timeout_err", err_cnt - ebase, 1);
    check_output("el_timeout_no_valid", valid_cnt - vbase, 0);
    check_output("el_timeout_frame_kept", {8'd0, EL_FRAME}, 32'h00FAC688);
    for (int b = 0; b < 8; b++) el_beat(3'(7 - b));
    repeat (4) @(negedge MCLK);
    check_output("el_frame2_valid", valid_cnt - vbase, 1);
    check_output("el_frame2", {8'd0, EL_FRAME}, 32'h00053977);
    check_output("el_frame2_err", err_cnt - ebase, 1);

    // Reset in the middle of a frame drops the partial beats silently.
    for (int b = 0; b < 4; b++) el_beat(3'd5);
    @(negedge MCLK);
    RESET = 1'b1;
    repeat (3) @(negedge MCLK);
    RESET = 1'b0;
    @(negedge MCLK);
    check_output("mid_reset_frame", {8'd0, EL_FRAME}, 32'd0);
    vbase = valid_cnt;
    ebase = err_cnt;
    el_beat(3'd1); el_beat(3'd3); el_beat(3'd5); el_beat(3'd7);
    el_beat(3'd0); el_beat(3'd2); el_beat(3'd4); el_beat(3'd6);
    repeat (1100) @(negedge MCLK);
    check_output("mid_reset_valid", valid_cnt - vbase, 1);
    check_output("mid_reset_frame3", {8'd0, EL_FRAME}, 32'h00D10F59);
    check_output("mid_reset_no_err", err_cnt - ebase, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cab_panel_rx.md
Name: cab_panel_rx

Overview:
- Cabinet-side receiver for the MVS front-panel outputs: LED_OUT1/LED_OUT2 (strobe + 8 data each) and EL_OUT (strobe + 3 data).
- Synchronises the strobes into the MCLK domain, latches the LED bytes, decodes them as two-digit BCD, and assembles EL beats into fixed-length frames.
- Sits in the bench/cabinet model opposite the neogeo_mvs panel drivers so tests can check panel traffic at word level.

Parameters:
- EL_BEATS, 8, EL strobes per frame; frame width = 3*EL_BEATS bits.
- EL_TIMEOUT, 1024, MCLK cycles without an EL strobe edge before a partial frame is dropped.
- SYNC_STAGES, 2, synchroniser flops on every input bit (minimum 2).

Ports:
- MCLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- LED_OUT1  in  9  [8]=strobe, [7:0]=data.
- LED_OUT2  in  9  [8]=strobe, [7:0]=data.
- EL_OUT  in  4  [3]=strobe, [2:0]=data.
- LED1_DATA  out  8  last latched LED1 byte.
- LED2_DATA  out  8  last latched LED2 byte.
- LED1_VAL  out  7  binary value of the LED1 BCD byte (0-99).
- LED2_VAL  out  7  binary value of the LED2 BCD byte.
- LED_BCD_ERR  out  2  sticky per channel; set when a latched nibble is >9.
- LED_UPD  out  2  one-cycle pulse per channel on each latch.
- EL_FRAME  out  3*EL_BEATS  last complete EL frame; beat 0 in the LSBs.
- EL_VALID  out  1  one-cycle pulse when EL_FRAME updates.
- EL_ERR  out  1  one-cycle pulse when a partial frame is dropped on timeout.
- SEG1  out  14  7-segment patterns for LED1, {tens, units}; only meaningful with the optional feature.
- SEG2  out  14  7-segment patterns for LED2, {tens, units}.

Behaviour:
- Reset:
  - All outputs are 0, the EL FSM is IDLE, and the beat and timeout counters are 0.
  - Synchroniser flops reset to 0, so a strobe that is high when reset is released produces one edge.
- Synchronisation:
  - Every input bit passes through SYNC_STAGES flops.
  - A rising edge is (synced strobe & ~delayed synced strobe).
  - Data is sampled from the synced data bits in the same cycle the edge is detected.
  - Sources must hold data stable for ≥ SYNC_STAGES+1 MCLK cycles around the strobe rising edge.
- LED channels (independent of each other):
  - On an edge, LEDn_DATA takes the data in the next cycle and LED_UPD[n] pulses in that same cycle.
  - Latency from the raw strobe edge to LED_UPD is SYNC_STAGES+1 cycles.
  - LEDn_VAL = 10*hi + lo, registered together with LEDn_DATA.
  - If either nibble is >9, VAL = 0 and LED_BCD_ERR[n] is set. It clears only on RESET.
  - Edges on both channels in the same cycle are both processed.
- EL FSM, states IDLE and RECV:
  - IDLE + edge: store beat 0, beat count = 1, go to RECV. With EL_BEATS=1 the frame completes immediately: emit it, stay in IDLE.
  - RECV + edge: store the beat at the current index and increment the count. When the count reaches EL_BEATS, EL_FRAME takes the full shift register, EL_VALID pulses, state returns to IDLE and the count returns to 0.
  - RECV: the timeout counter increments every cycle and clears on each edge. When it reaches EL_TIMEOUT-1 with no edge, EL_ERR pulses, the partial frame is discarded, EL_FRAME is unchanged and the state returns to IDLE.
  - Edge and timeout in the same cycle: the edge wins and the counter clears.
  - IDLE: the timeout counter is held at 0.
- RESET mid-frame discards the partial frame and raises no EL_ERR.

Optional Feature:
- Macro: CAB_PANEL_SEG_DECODE_EN.
- Defined: SEG1/SEG2 carry registered 7-segment patterns (bit order gfedcba, active-high) for each nibble. Patterns update in the same cycle as LED_UPD; nibbles >9 drive blank (0).
- Undefined: no decoder logic is built and SEG1/SEG2 are tied to 0. The port list is unchanged.

Decomposition:
- Shared package cab_panel_pkg:
  - EL FSM state enum.
  - 7-segment lookup constants for digits 0-9 plus blank.
  - Default values of EL_TIMEOUT and EL_BEATS.
- Sub-module strobe_sync: SYNC_STAGES-deep synchroniser plus rising-edge detect, parameterised on data width.
  - Instantiated three times: LED1, LED2 and EL.

Test Plan:
- LED_OUT1 data 0x42 with a strobe high for 10 MCLK → LED_UPD[0] pulses once at cycle 3 after the raw edge; LED1_DATA=0x42, LED1_VAL=42, LED_BCD_ERR=00.
- LED_OUT2 data 0x3A with a strobe → LED2_VAL=0 and LED_BCD_ERR[1]=1. A following 0x07 gives LED2_VAL=7 with ERR still 1.
- 8 EL strobes carrying data 0..7 → one EL_VALID pulse after the 8th; EL_FRAME=0xFAC688 (3-bit beats 7,6,…,0 from MSB down).
- 3 EL strobes, then silence for 1100 MCLK → EL_ERR pulses once; EL_FRAME keeps its previous value. The next 8 strobes form a clean frame.
- RESET asserted after 4 EL beats, then 8 beats → a single EL_VALID with the new frame; no EL_ERR.
- With CAB_PANEL_SEG_DECODE_EN, LED1 = 0x18 → SEG1 = {0x06, 0x7F}. Without the macro, SEG1 stays 0.
